exc_controller: RTL
===================

EXC_CONTROLLER -- requirements
Module: exc_controller

Interface
REQ-001 Parameter NLINES, default 4, number of external interrupt lines; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 irq  input  NLINES  external interrupt lines, asynchronous to clk, rising-edge significant.
REQ-005 irq_mask  input  NLINES  bit i = 1 blocks line i from raising a request; it does not block capture into pending.
REQ-006 ExcAck  input  1  core acknowledges the exception, taking the vector this cycle.
REQ-007 ERet  input  1  core executes exception return, closing the handler.
REQ-008 Exc  output  1  exception request to core, registered.
REQ-009 EStatus  output  4  cause code of the current request, registered.
REQ-010 pending  output  NLINES  captured, not yet acknowledged interrupts.
REQ-011 busy  output  1  high while in state SERVICE.

Function
REQ-012 Each irq bit SHALL pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-013 A rising edge is synchronizer output = 1 and history = 0; it SHALL set pending[i] on the next clock edge.
REQ-014 Timing: irq is first sampled high at edge t; pending[i] SHALL read 1 after edge t+2; from IDLE with line unmasked, Exc SHALL read 1 after edge t+3.
REQ-015 FSM states: IDLE, REQ, SERVICE; encoding is free.
REQ-016 IDLE, with (pending & ~irq_mask) nonzero: go to REQ next edge; select lowest index i among those bits; load EStatus = 4'b1000 + i; set Exc = 1.
REQ-017 IDLE, with no unmasked pending bit: stay; Exc = 0; EStatus holds its last value.
REQ-018 REQ: Exc and EStatus SHALL hold stable until ExcAck = 1, regardless of irq_mask changes or new edges on other lines.
REQ-019 REQ, with ExcAck = 1: next edge clears pending of the selected line, clears Exc, and moves to SERVICE.
REQ-020 SERVICE: busy = 1 and Exc = 0; new edges still capture into pending; on ERet = 1, go to IDLE next edge.
REQ-021 From IDLE after SERVICE, a remaining unmasked pending bit SHALL raise Exc one edge later; there are no back-to-back requests without passing through IDLE.
REQ-022 Simultaneous set and clear of the same pending bit: the set wins, so the bit stays 1.
REQ-023 Ignored inputs: ExcAck outside REQ, and ERet outside SERVICE, SHALL have no effect.
REQ-024 A line held high produces exactly one pending set per low-to-high transition; it is not level-retriggered.
REQ-025 When masked lines are unmasked in IDLE, their stored pending bits SHALL raise a request per REQ-016.

Reset
REQ-026 reset = 1 SHALL immediately force the following, independent of clk:
- state = IDLE
- Exc = 0, EStatus = 4'b0000
- pending = 0, busy = 0
- all synchronizer and history flops = 0
REQ-027 Reset asserted while in REQ or SERVICE SHALL abandon the request; no pending bit survives.
REQ-028 After reset deasserts, an irq line already high SHALL count as a rising edge and set pending per REQ-014.

Verification
REQ-029 irq[2] pulses high for 3 cycles, mask = 0 -> pending[2] = 1 after edge t+2; Exc = 1 with EStatus = 4'b1010 after edge t+3; Exc holds until ExcAck; ExcAck -> Exc = 0, busy = 1, pending[2] = 0.
REQ-030 irq[1] and irq[3] rise in the same cycle -> first request EStatus = 4'b1001. ExcAck, then ERet -> second request EStatus = 4'b1011, one edge after IDLE is reached.
REQ-031 irq_mask[0] = 1, irq[0] rises -> pending[0] = 1 and Exc stays 0. Clearing irq_mask[0] -> Exc = 1, EStatus = 4'b1000 on the next edge.
REQ-032 In REQ for line 1, a new irq[1] edge lands in the ExcAck clear cycle -> pending[1] remains 1. After ERet, a second request for line 1 follows.
REQ-033 Stray ExcAck in IDLE and stray ERet in REQ -> no state change, and Exc remains as before.
REQ-034 Async reset pulsed mid-SERVICE, between clock edges -> Exc = 0, busy = 0, pending = 0 before the next edge.

Source files
------------

// File: rtl/exc_controller.sv
`default_nettype none
// ============================================================================
// Module      : exc_controller
// Description : Interrupt-to-exception controller. Synchronizes NLINES
//               external interrupt lines, latches their rising edges into
//               pending bits and presents one request at a time to the core.
//               The request carries the cause code of the lowest-index
//               unmasked pending line.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_controller #(
    parameter int NLINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NLINES-1:0] irq,
    input  logic [NLINES-1:0] irq_mask,
    input  logic              ExcAck,
    input  logic              ERet,
    output logic              Exc,
    output logic [3:0]        EStatus,
    output logic [NLINES-1:0] pending,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NLINES-1:0] sync1_q, sync1_d;
    logic [NLINES-1:0] sync2_q, sync2_d;
    logic [NLINES-1:0] hist_q, hist_d;
    logic [NLINES-1:0] pending_q, pending_d;
    logic [1:0]        state_q, state_d;
    logic              exc_q, exc_d;
    logic [3:0]        estatus_q, estatus_d;
    logic [2:0]        sel_q, sel_d;

    logic [NLINES-1:0] rise;
    logic [NLINES-1:0] cand;
    logic [NLINES-1:0] clr;
    logic [2:0]        low_idx;

    // A rising edge is a synchronized 1 whose previous sample was 0
    assign rise = sync2_q & ~hist_q;
    // Only unmasked pending lines may raise a request
    assign cand = pending_q & ~irq_mask;

    // Two-stage synchronizer followed by one history stage
    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Lowest index among unmasked pending lines wins
    always_comb begin
        low_idx = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Clear vector for the line being acknowledged
    always_comb begin
        clr = '0;
        for (int i = 0; i < NLINES; i++) begin
            clr[i] = (state_q == ST_REQ) && ExcAck && (sel_q == 3'(i));
        end
    end

    // Request FSM; a new edge on the acknowledged line overrides its clear
    always_comb begin
        state_d   = state_q;
        exc_d     = exc_q;
        estatus_d = estatus_q;
        sel_d     = sel_q;
        pending_d = (pending_q & ~clr) | rise;
        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    state_d   = ST_REQ;
                    sel_d     = low_idx;
                    exc_d     = 1'b1;
                    estatus_d = 4'b1000 + {1'b0, low_idx};
                end else begin
                    exc_d = 1'b0;
                end
            end
            ST_REQ: begin
                // Exc and EStatus are frozen until the core takes the vector
                if (ExcAck) begin
                    exc_d   = 1'b0;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                exc_d = 1'b0;
                if (ERet) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                exc_d   = 1'b0;
            end
        endcase
    end

    // State registers, all cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            exc_q     <= 1'b0;
            estatus_q <= 4'b0000;
            sel_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            exc_q     <= exc_d;
            estatus_q <= estatus_d;
            sel_q     <= sel_d;
        end
    end

    assign Exc     = exc_q;
    assign EStatus = estatus_q;
    assign pending = pending_q;
    assign busy    = (state_q == ST_SERVICE);

endmodule
`default_nettype wire
